// File: rtl/nf10_endian_pkg.sv
// Swap-mode encodings and byte-permutation helpers shared by the endian swap pipe.
package nf10_endian_pkg;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_16   = 3'd1;
  localparam logic [2:0] MODE_32   = 3'd2;
  localparam logic [2:0] MODE_64   = 3'd3;
  localparam logic [2:0] MODE_FULL = 3'd4;

  typedef enum logic {ST_SOP = 1'b0, ST_IN_PKT = 1'b1} pkt_state_e;

  function automatic int unsigned group_bytes(input logic [2:0] mode, input int unsigned data_width);
    case (mode)
      MODE_NONE: return 1;
      MODE_16:   return 2;
      MODE_32:   return 4;
      MODE_64:   return 8;
      default:   return data_width / 8;
    endcase
  endfunction

  // Source byte index for output byte k when bytes are reversed inside g-byte groups.
  function automatic int unsigned swap_src(input int unsigned k, input int unsigned g);
    return (k / g) * g + (g - 1) - (k % g);
  endfunction

endpackage

// File: rtl/endian_swap_lane.sv
// Combinational byte/strobe permutation for one beat; mode selects the reversal group size.
module endian_swap_lane
  import nf10_endian_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic [DATA_WIDTH-1:0]   tdata,
  input  logic [DATA_WIDTH/8-1:0] tstrb,
  input  logic [2:0]              mode,
  output logic [DATA_WIDTH-1:0]   swp_tdata,
  output logic [DATA_WIDTH/8-1:0] swp_tstrb
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = $clog2(NB);

  logic [NB-1:0][7:0] din, dout;

  assign din       = tdata;
  assign swp_tdata = dout;

  // Each output byte is a 5:1 mux over constant source indices.
  for (genvar k = 0; k < NB; k++) begin : g_byte
    localparam logic [IW-1:0] S0    = IW'(k);
    localparam logic [IW-1:0] S16   = IW'(swap_src(k, group_bytes(MODE_16, DATA_WIDTH)));
    localparam logic [IW-1:0] S32   = IW'(swap_src(k, group_bytes(MODE_32, DATA_WIDTH)));
    localparam logic [IW-1:0] S64   = IW'(swap_src(k, group_bytes(MODE_64, DATA_WIDTH)));
    localparam logic [IW-1:0] SFULL = IW'(swap_src(k, group_bytes(MODE_FULL, DATA_WIDTH)));

    logic [IW-1:0] src;

    always_comb begin
      case (mode)
        MODE_NONE: src = S0;
        MODE_16:   src = S16;
        MODE_32:   src = S32;
        MODE_64:   src = S64;
        default:   src = SFULL;
      endcase
    end

    assign dout[k]      = din[src];
    assign swp_tstrb[k] = tstrb[src];
  end

endmodule

// File: rtl/axis_endian_swap_pipe.sv
// Registered AXI-Stream endian swapper: per-packet latched mode, swap before the
// output/skid register pair, registered s_axis_tready.
module axis_endian_swap_pipe
  import nf10_endian_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEFAULT_MODE     = 4,
  parameter int C_PKT_CNT_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2:0]                      swap_mode,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [2:0]                      active_mode,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_count
);

  localparam int NB = C_AXIS_DATA_WIDTH / 8;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  data;
    logic [NB-1:0]                 strb;
    logic [C_AXIS_TUSER_WIDTH-1:0] user;
    logic                          last;
  } beat_t;

  pkt_state_e                 state_q, state_d;
  logic [2:0]                 active_mode_q, active_mode_d, cur_mode;
  logic [C_PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  beat_t                      out_q, out_d, skid_q, skid_d, in_beat;
  logic                       out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic                       s_rdy_q, s_rdy_d;
  logic                       acc;
  logic [C_AXIS_DATA_WIDTH-1:0] swp_tdata;
  logic [NB-1:0]                swp_tstrb;

  assign acc = s_axis_tvalid & s_rdy_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_SOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc) state_d = s_axis_tlast ? ST_SOP : ST_IN_PKT;
  end

  // A start-of-packet beat uses the incoming swap_mode directly, not the stale latch.
  always_comb begin
    cur_mode      = (state_q == ST_SOP) ? swap_mode : active_mode_q;
    active_mode_d = (acc && state_q == ST_SOP) ? swap_mode : active_mode_q;
  end

  endian_swap_lane #(
    .DATA_WIDTH(C_AXIS_DATA_WIDTH)
  ) u_swap (
    .tdata     (s_axis_tdata),
    .tstrb     (s_axis_tstrb),
    .mode      (cur_mode),
    .swp_tdata (swp_tdata),
    .swp_tstrb (swp_tstrb)
  );

  assign in_beat = '{data: swp_tdata, strb: swp_tstrb, user: s_axis_tuser, last: s_axis_tlast};

  // Skid is only ever filled while the output is stalled, so it can never hold
  // a beat with the output empty; when it drains, tready was low and acc is 0.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || m_axis_tready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = acc;
        if (acc) out_d = in_beat;
      end
    end else if (acc) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
    s_rdy_d     = ~skid_vld_d;
    pkt_count_d = pkt_count_q + {{(C_PKT_CNT_WIDTH-1){1'b0}}, acc & s_axis_tlast};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q         <= '0;
      out_vld_q     <= 1'b0;
      skid_q        <= '0;
      skid_vld_q    <= 1'b0;
      s_rdy_q       <= 1'b0;
      pkt_count_q   <= '0;
      active_mode_q <= 3'(C_DEFAULT_MODE);
    end else begin
      out_q         <= out_d;
      out_vld_q     <= out_vld_d;
      skid_q        <= skid_d;
      skid_vld_q    <= skid_vld_d;
      s_rdy_q       <= s_rdy_d;
      pkt_count_q   <= pkt_count_d;
      active_mode_q <= active_mode_d;
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tstrb  = out_q.strb;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tlast  = out_q.last;
  assign active_mode   = active_mode_q;
  assign pkt_count     = pkt_count_q;

endmodule
